// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with hazard-unit stall/flush hooks.
// Latency: 1 cycle from CtrlD/DataD/ValidD to CtrlE/DataE/ValidE.
// Backpressure: StallE holds all state, FlushE inserts a zeroed bubble and wins over StallE.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   StallE, FlushE    : hazard-unit hold and bubble requests (priority rst > FlushE > StallE > load)
//   ValidD/CtrlD/DataD: decode-stage instruction (valid, packed control, packed data)
//   ValidE/CtrlE/DataE: registered execute-stage instruction
//   StallCntE/FlushCntE: saturating stall/flush cycle counters, present only
//                        when the PIPE_REG_PERF_EN macro is defined
//
// Optional feature macro: PIPE_REG_PERF_EN (adds CNT_W parameter and the counters).
module pipe_reg_de #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 165
`ifdef PIPE_REG_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [DATA_W-1:0] DataD,
    output logic              ValidE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [DATA_W-1:0] DataE
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  StallCntE,
    output logic [CNT_W-1:0]  FlushCntE
`endif
);

    // Main pipeline state. Flush is checked before stall so that a combined
    // load-use + taken-branch request always produces a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidE <= 1'b0;
            CtrlE  <= '0;
            DataE  <= '0;
        end else if (FlushE) begin
            ValidE <= 1'b0;
            CtrlE  <= '0;
            DataE  <= '0;
        end else if (!StallE) begin
            ValidE <= ValidD;
            // Squash control of an invalid decode slot so that RegWrite and
            // MemWrite can never fire downstream; data is passed untouched.
            CtrlE  <= ValidD ? CtrlD : '0;
            DataE  <= DataD;
        end
        // StallE=1, FlushE=0: hold everything, including a bubble.
    end

`ifdef PIPE_REG_PERF_EN
    // Counters saturate at all-ones rather than wrapping so a long run never
    // reports a misleadingly small number.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCntE <= '0;
            FlushCntE <= '0;
        end else begin
            if (FlushE && (FlushCntE != {CNT_W{1'b1}})) begin
                FlushCntE <= FlushCntE + 1'b1;
            end
            // A stall that coincides with a flush is not counted as a stall.
            if (StallE && !FlushE && (StallCntE != {CNT_W{1'b1}})) begin
                StallCntE <= StallCntE + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_de.sv
module tb_pipe_reg_de;

    localparam int CTRL_W = 10;
    localparam int DATA_W = 165;
`ifdef PIPE_REG_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              StallE;
    logic              FlushE;
    logic              ValidD;
    logic [CTRL_W-1:0] CtrlD;
    logic [DATA_W-1:0] DataD;
    logic              ValidE;
    logic [CTRL_W-1:0] CtrlE;
    logic [DATA_W-1:0] DataE;
`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0]  StallCntE;
    logic [CNT_W-1:0]  FlushCntE;
`endif

    always #5 clk = ~clk;

    pipe_reg_de #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
`ifdef PIPE_REG_PERF_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .StallE(StallE),
        .FlushE(FlushE),
        .ValidD(ValidD),
        .CtrlD (CtrlD),
        .DataD (DataD),
        .ValidE(ValidE),
        .CtrlE (CtrlE),
        .DataE (DataE)
`ifdef PIPE_REG_PERF_EN
        ,
        .StallCntE(StallCntE),
        .FlushCntE(FlushCntE)
`endif
    );

    // One stimulus record: inputs for one edge plus the outputs required after it.
    typedef struct {
        string             name;
        logic              rst;
        logic              flush;
        logic              stall;
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              e_vld;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    typedef struct {
        string             name;
        logic              e_vld;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
        int                e_scnt;
        int                e_fcnt;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Expected performance counters, following the counting rules directly.
    int   m_scnt = 0;
    int   m_fcnt = 0;

    function automatic vec_t mk(string nm, logic r, logic f, logic s, logic v,
                                logic [CTRL_W-1:0] c, logic [DATA_W-1:0] d,
                                logic ev, logic [CTRL_W-1:0] ec, logic [DATA_W-1:0] ed);
        vec_t x;
        x.name = nm; x.rst = r; x.flush = f; x.stall = s; x.vld = v;
        x.ctrl = c; x.data = d; x.e_vld = ev; x.e_ctrl = ec; x.e_data = ed;
        return x;
    endfunction

    task automatic cmp(string nm, logic [DATA_W-1:0] got, logic [DATA_W-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h", nm, got, want);
        end
    endtask

    // Drive one record after the previous edge, push its expectation, then
    // check after the next edge.
    task automatic apply(vec_t v);
        exp_t e;
        rst    = v.rst;
        FlushE = v.flush;
        StallE = v.stall;
        ValidD = v.vld;
        CtrlD  = v.ctrl;
        DataD  = v.data;
`ifdef PIPE_REG_PERF_EN
        if (v.rst) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (v.flush && m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
            if (v.stall && !v.flush && m_scnt < (1 << CNT_W) - 1) m_scnt++;
        end
`endif
        e.name = v.name; e.e_vld = v.e_vld; e.e_ctrl = v.e_ctrl; e.e_data = v.e_data;
        e.e_scnt = m_scnt; e.e_fcnt = m_fcnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
            return;
        end
        e = sb_q.pop_front();
        cmp({e.name, ".ValidE"}, DATA_W'(ValidE), DATA_W'(e.e_vld));
        cmp({e.name, ".CtrlE"},  DATA_W'(CtrlE),  DATA_W'(e.e_ctrl));
        cmp({e.name, ".DataE"},  DataE,           e.e_data);
`ifdef PIPE_REG_PERF_EN
        cmp({e.name, ".StallCntE"}, DATA_W'(StallCntE), DATA_W'(e.e_scnt));
        cmp({e.name, ".FlushCntE"}, DATA_W'(FlushCntE), DATA_W'(e.e_fcnt));
`endif
    endtask

    // Hard stop in case the bench itself ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    initial begin
        vec_t tbl[$];
        vec_t v;

        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0; CtrlD = '0; DataD = '0;
        @(posedge clk);
        #1;

        //            name               rst  flsh stl  vld  ctrl     data  -> vld  ctrl     data
        tbl.push_back(mk("reset_1",        1, 0, 0, 1, 10'h3FF, ONES,    0, 10'h000, '0));
        tbl.push_back(mk("reset_2",        1, 0, 0, 1, 10'h3FF, ONES,    0, 10'h000, '0));
        tbl.push_back(mk("first_load",     0, 0, 0, 1, 10'h3FF, ONES,    1, 10'h3FF, ONES));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk("stream", 0, 0, 0, 1, 10'h012, DATA_W'(k), 1, 10'h012, DATA_W'(k)));
        tbl.push_back(mk("load_aa",        0, 0, 0, 1, 10'h155, 'hAA,    1, 10'h155, 'hAA));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk("stall_hold", 0, 0, 1, 1, 10'h0F0, 'hBB,    1, 10'h155, 'hAA));
        tbl.push_back(mk("stall_release",  0, 0, 0, 1, 10'h0F0, 'hBB,    1, 10'h0F0, 'hBB));
        tbl.push_back(mk("load_155",       0, 0, 0, 1, 10'h155, 'h77,    1, 10'h155, 'h77));
        tbl.push_back(mk("flush_and_stall",0, 1, 1, 1, 10'h3FF, 'h66,    0, 10'h000, '0));
        tbl.push_back(mk("invalid_decode", 0, 0, 0, 0, 10'h3FF, 'h55,    0, 10'h000, 'h55));
        tbl.push_back(mk("flush_only",     0, 1, 0, 1, 10'h3FF, 'h44,    0, 10'h000, '0));
        tbl.push_back(mk("stall_bubble",   0, 0, 1, 1, 10'h3FF, 'h99,    0, 10'h000, '0));
        tbl.push_back(mk("stall_bubble_2", 0, 0, 1, 1, 10'h2AA, 'h98,    0, 10'h000, '0));
        tbl.push_back(mk("load_2aa",       0, 0, 0, 1, 10'h2AA, 'h123,   1, 10'h2AA, 'h123));
        tbl.push_back(mk("rst_mid_stall",  1, 0, 1, 1, 10'h3FF, 'h456,   0, 10'h000, '0));
        tbl.push_back(mk("load_after_rst", 0, 0, 0, 1, 10'h2AA, 'h321,   1, 10'h2AA, 'h321));
        tbl.push_back(mk("rst_mid_flush",  1, 1, 0, 1, 10'h3FF, 'h456,   0, 10'h000, '0));
        tbl.push_back(mk("load_after_rst2",0, 0, 0, 1, 10'h001, ONES,    1, 10'h001, ONES));

        foreach (tbl[i]) apply(tbl[i]);

        // Long stall: data must hold for 20 edges and counters saturate.
        apply(mk("sat_prep_rst", 1, 0, 0, 0, 10'h000, '0,   0, 10'h000, '0));
        apply(mk("sat_load",     0, 0, 0, 1, 10'h0C3, 'h5A, 1, 10'h0C3, 'h5A));
        for (int k = 0; k < 20; k++)
            apply(mk("long_stall", 0, 0, 1, 1, 10'h3FF, 'hA5, 1, 10'h0C3, 'h5A));
`ifdef PIPE_REG_PERF_EN
        cmp("stall_cnt_saturated", DATA_W'(StallCntE), DATA_W'(15));
`endif
        apply(mk("sat_clear_rst", 1, 0, 1, 1, 10'h3FF, 'hA5, 0, 10'h000, '0));
`ifdef PIPE_REG_PERF_EN
        cmp("stall_cnt_cleared", DATA_W'(StallCntE), DATA_W'(0));
`endif

        // Random-ish stream with no hazards: output equals previous input.
        for (int k = 0; k < 8; k++) begin
            v = mk("rand_stream", 0, 0, 0, 1, CTRL_W'($urandom), DATA_W'({$urandom, $urandom}),
                   1, 10'h000, '0);
            v.e_ctrl = v.ctrl;
            v.e_data = v.data;
            apply(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_reg_de.md
Name: pipe_reg_de

Overview:
- Parametrised decode-to-execute (D→E) pipeline register; successor to the fixed single-bit D/E register.
- Carries a valid bit plus generic control and data buses of configurable width.
- Adds hazard-unit hooks: stall (hold) and flush (bubble insertion), plus a synchronous reset.
- Sits between the decode stage (register file, immediate extend, control decoder) and the execute stage (ALU, branch compare).

Parameters:
- CTRL_W, 10, width of the packed control bus (RegWrite, ResultSrc[1:0], MemWrite, J, Branch, ALUControl[2:0], ALUSrc).
- DATA_W, 165, width of the packed data bus (RD1, RD2, PC, ext, PCPlus4 at 32 bits each, plus Rd at 5 bits).
- CNT_W, 32, width of the performance counters; only used when PIPE_REG_PERF_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- StallE  input  1  hold request from the hazard unit.
- FlushE  input  1  bubble request from the hazard unit (branch taken or load-use).
- ValidD  input  1  decode-stage instruction is valid.
- CtrlD  input  CTRL_W  packed decode control.
- DataD  input  DATA_W  packed decode data.
- ValidE  output  1  execute-stage instruction is valid.
- CtrlE  output  CTRL_W  registered control.
- DataE  output  DATA_W  registered data.
- StallCntE  output  CNT_W  stall cycle count (PIPE_REG_PERF_EN only).
- FlushCntE  output  CNT_W  flush cycle count (PIPE_REG_PERF_EN only).

Behaviour:
- Reset and clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: while rst=1 at a rising edge, ValidE=0, CtrlE=0, DataE=0, and both counters are 0.
- Priority at each rising edge: rst > FlushE > StallE > load.
- Load (rst=0, FlushE=0, StallE=0):
  - ValidE←ValidD, CtrlE←CtrlD, DataE←DataD.
  - Latency is exactly 1 cycle.
- If ValidD=0 during a load, CtrlE←0 regardless of CtrlD. An invalid instruction therefore never asserts RegWrite or MemWrite downstream; DataE still loads.
- Flush (FlushE=1): ValidE←0, CtrlE←0, DataE←0, so a clean bubble is inserted. Inputs are ignored.
- Flush and stall together (FlushE=1, StallE=1): flush wins and a bubble is inserted. The hazard unit relies on this for load-use combined with branch.
- Stall (StallE=1, FlushE=0): ValidE, CtrlE and DataE hold their current values. Stall can be held for any number of cycles.
- Stalling a bubble (ValidE=0) keeps the bubble and must not resurrect stale inputs.
- Outputs are driven only from registers; there is no combinational path from input to output.
- Reset mid-stall or mid-flush: reset wins in the same edge, and the next cycle behaves as a normal load.
- Exact width: inputs are registered bit-for-bit, with no truncation or extension. A width of CTRL_W=1 or DATA_W=1 must elaborate.

Optional Feature:
- Macro: PIPE_REG_PERF_EN.
- Defined:
  - StallCntE increments on every edge with rst=0, StallE=1 and FlushE=0.
  - FlushCntE increments on every edge with rst=0 and FlushE=1.
  - Both counters saturate at 2^CNT_W−1 (no wrap) and are cleared only by rst.
- Undefined: the StallCntE/FlushCntE ports and all counter logic are absent, and CNT_W is unused.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with CtrlD=10'h3FF, DataD all-ones, ValidD=1 → ValidE=0, CtrlE=0, DataE=0. With rst=0 and no stall, the next edge gives ValidE=1, CtrlE=10'h3FF.
2. Streaming: apply ValidD=1 with DataD=1,2,3,4 on consecutive cycles, no stall or flush → DataE=1,2,3,4, each one cycle later; ValidE stays 1.
3. Stall hold: load DataD=0xAA, then StallE=1 for 3 cycles while DataD=0xBB → DataE stays 0xAA for 3 cycles; DataE becomes 0xBB one cycle after StallE drops. With PERF, StallCntE=3.
4. Flush priority: with CtrlE=10'h155, assert FlushE=1 and StallE=1 together → the next edge gives ValidE=0, CtrlE=0, DataE=0. With PERF, FlushCntE=1 and StallCntE is unchanged.
5. Invalid decode: ValidD=0 with CtrlD=10'h3FF and DataD=0x55 → CtrlE=0, DataE=0x55, ValidE=0.
6. Saturation (PERF, CNT_W=4): hold StallE=1 for 20 cycles → StallCntE reaches 15 and stays at 15. Pulse rst=1 → StallCntE=0.
